// File: rtl/uart_rx_oversample.sv
// Oversampling UART receiver: 16 sample ticks per bit, 7/8/9 majority vote,
// optional parity, framing-error and break detection on the system clock.
module uart_rx_oversample #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_enable,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       parity_err,
    output logic [2:0] state_dbg
);

    localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [TW-1:0] DIV_M1 = TW'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      sync_q, sync_d;
    logic            prev_q, prev_d;
    logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [3:0]      samp_cnt_q, samp_cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            s7_q, s7_d, s8_q, s8_d;
    logic            par_bit_q, par_bit_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            frame_err_q, frame_err_d;
    logic            parity_err_q, parity_err_d;

    logic rx_s, fall, tick, decide, bit_end, bit_val, parity_ok;

    always_comb begin
        rx_s      = sync_q[1];
        fall      = prev_q & ~rx_s;
        tick      = (tick_cnt_q == DIV_M1);
        decide    = tick && (samp_cnt_q == 4'd9);
        bit_end   = tick && (samp_cnt_q == 4'd15);
        bit_val   = (s7_q & s8_q) | (s7_q & rx_s) | (s8_q & rx_s);
        parity_ok = !PARITY_EN || ((^shift_q ^ par_bit_q) == PARITY_ODD);

        sync_d       = {sync_q[0], rx_in};
        prev_d       = rx_s;
        state_d      = state_q;
        tick_cnt_d   = tick ? '0 : tick_cnt_q + 1'b1;
        samp_cnt_d   = tick ? samp_cnt_q + 4'd1 : samp_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        s7_d         = (tick && samp_cnt_q == 4'd7) ? rx_s : s7_q;
        s8_d         = (tick && samp_cnt_q == 4'd8) ? rx_s : s8_q;
        par_bit_d    = par_bit_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Counters restart on the edge so sampling is centred on the bit.
                if (rx_enable && fall) begin
                    state_d    = START;
                    tick_cnt_d = '0;
                    samp_cnt_d = 4'd0;
                    bit_cnt_d  = 3'd0;
                    par_bit_d  = 1'b0;
                end
            end
            START: begin
                if (decide && bit_val) begin
                    state_d = IDLE;
                end else if (bit_end) begin
                    state_d   = DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            DATA: begin
                if (decide) begin
                    shift_d = {bit_val, shift_q[7:1]};
                end
                if (bit_end) begin
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY_EN ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (decide) begin
                    par_bit_d = bit_val;
                end
                if (bit_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                // Leave at the stop decision so the next start edge is never missed.
                if (decide) begin
                    state_d = IDLE;
                    if (!bit_val) begin
                        frame_err_d = 1'b1;
                        if (shift_q == 8'h00 && !par_bit_q) begin
                            state_d = BREAK;
                        end
                    end else if (!parity_ok) begin
                        parity_err_d = 1'b1;
                    end else begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = shift_q;
                    end
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!rx_enable) begin
            state_d      = IDLE;
            rx_data_d    = rx_data_q;
            rx_valid_d   = 1'b0;
            frame_err_d  = 1'b0;
            parity_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sync_q       <= 2'b11;
            prev_q       <= 1'b1;
            tick_cnt_q   <= '0;
            samp_cnt_q   <= 4'd0;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            s7_q         <= 1'b1;
            s8_q         <= 1'b1;
            par_bit_q    <= 1'b0;
            rx_data_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            prev_q       <= prev_d;
            tick_cnt_q   <= tick_cnt_d;
            samp_cnt_q   <= samp_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            s7_q         <= s7_d;
            s8_q         <= s8_d;
            par_bit_q    <= par_bit_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign rx_busy    = (state_q != IDLE);
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Bench for uart_rx_oversample: one 8N1 receiver and one 8E1 receiver, directed
// scenarios plus random frames scored against a frame-level outcome model.
module tb_uart_rx_oversample;

    localparam int BIT_CLK = 64;
    localparam logic [1:0] EV_VALID = 2'd1;
    localparam logic [1:0] EV_FERR  = 2'd2;
    localparam logic [1:0] EV_PERR  = 2'd3;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_BREAK = 3'd5;

    logic       clk = 1'b0;
    logic       rst;
    logic       en_a, en_b, rx_a, rx_b;
    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b, busy_a, busy_b;
    logic       ferr_a, ferr_b, perr_a, perr_b;
    logic [2:0] st_a, st_b;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;
    int fall_cyc = 0;
    int pulse_cyc_a = 0;

    logic [9:0] exp_a[$], exp_b[$], obs_a[$], obs_b[$];
    logic [7:0] exp_data_a = 8'h00;
    logic [7:0] exp_data_b = 8'h00;

    uart_rx_oversample #(.CLK_FREQ(640), .BAUD_RATE(10), .OVERSAMPLE(16),
                         .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut_a (
        .clk(clk), .rst(rst), .rx_enable(en_a), .rx_in(rx_a),
        .rx_data(data_a), .rx_valid(valid_a), .rx_busy(busy_a),
        .frame_err(ferr_a), .parity_err(perr_a), .state_dbg(st_a)
    );

    uart_rx_oversample #(.CLK_FREQ(640), .BAUD_RATE(10), .OVERSAMPLE(16),
                         .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_b (
        .clk(clk), .rst(rst), .rx_enable(en_b), .rx_in(rx_b),
        .rx_data(data_b), .rx_valid(valid_b), .rx_busy(busy_b),
        .frame_err(ferr_b), .parity_err(perr_b), .state_dbg(st_b)
    );

    // Clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: got no finish, expected finish before 95000 cycles");
        $fatal(1, "watchdog expired");
    end

    // Event monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            if (valid_a) begin obs_a.push_back({EV_VALID, data_a}); pulse_cyc_a = cyc; end
            if (ferr_a)  begin obs_a.push_back({EV_FERR, 8'h00});   pulse_cyc_a = cyc; end
            if (perr_a)  begin obs_a.push_back({EV_PERR, 8'h00});   pulse_cyc_a = cyc; end
            if (valid_b) obs_b.push_back({EV_VALID, data_b});
            if (ferr_b)  obs_b.push_back({EV_FERR, 8'h00});
            if (perr_b)  obs_b.push_back({EV_PERR, 8'h00});
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Reference model: outcome of one frame from its byte, parity bit and stop bit
    function automatic logic [9:0] model_frame(input logic [7:0] b, input logic par,
                                               input logic stop, input bit par_en);
        if (!stop) return {EV_FERR, 8'h00};
        if (par_en && (^{b, par})) return {EV_PERR, 8'h00};
        return {EV_VALID, b};
    endfunction

    task automatic expect_frame(input int d, input logic [7:0] b, input logic par, input logic stop);
        logic [9:0] ev;
        ev = model_frame(b, par, stop, d == 1);
        if (d == 0) begin
            exp_a.push_back(ev);
            if (ev[9:8] == EV_VALID) exp_data_a = ev[7:0];
        end else begin
            exp_b.push_back(ev);
            if (ev[9:8] == EV_VALID) exp_data_b = ev[7:0];
        end
    endtask

    // Driver tasks
    task automatic set_rx(input int d, input logic v);
        if (d == 0) rx_a = v;
        else        rx_b = v;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input int d, input logic [7:0] b, input logic par,
                              input logic stop, input int bc);
        fall_cyc = cyc;
        set_rx(d, 1'b0);
        idle(bc);
        for (int i = 0; i < 8; i++) begin
            set_rx(d, b[i]);
            idle(bc);
        end
        if (d == 1) begin
            set_rx(d, par);
            idle(bc);
        end
        set_rx(d, stop);
        idle(bc);
        set_rx(d, 1'b1);
    endtask

    // Scoreboard: drain observed events against the expected queue
    task automatic score(input int d, input string tag);
        logic [9:0] o[$];
        logic [9:0] e[$];
        if (d == 0) begin
            o = obs_a; e = exp_a; obs_a.delete(); exp_a.delete();
        end else begin
            o = obs_b; e = exp_b; obs_b.delete(); exp_b.delete();
        end
        check({tag, "_count"}, o.size(), e.size());
        for (int i = 0; i < e.size() && i < o.size(); i++) begin
            check({tag, "_event"}, o[i], e[i]);
        end
    endtask

    initial begin
        int lat;
        logic [7:0] b;
        logic stop, par;
        int bc;

        rst = 1'b1; en_a = 1'b1; en_b = 1'b1; rx_a = 1'b1; rx_b = 1'b1;
        idle(4);
        check("rst_data",   data_a, 8'h00);
        check("rst_valid",  valid_a, 1'b0);
        check("rst_busy",   busy_a, 1'b0);
        check("rst_ferr",   ferr_a, 1'b0);
        check("rst_perr",   perr_a, 1'b0);
        check("rst_state",  st_a, ST_IDLE);
        check("rst_busy_b", busy_b, 1'b0);
        rst = 1'b0;
        idle(8);

        // 0x55 8N1, busy over the frame, result latency
        fork
            send_frame(0, 8'h55, 1'b0, 1'b1, BIT_CLK);
            begin
                idle(10);
                check("busy_early", busy_a, 1'b1);
                idle(600);
                check("busy_late", busy_a, 1'b1);
            end
        join
        expect_frame(0, 8'h55, 1'b0, 1'b1);
        idle(BIT_CLK);
        lat = pulse_cyc_a - fall_cyc;
        check("latency", (lat >= 619 && lat <= 621) ? 620 : lat, 620);
        check("busy_after", busy_a, 1'b0);
        score(0, "byte55");
        check("data55", data_a, exp_data_a);

        // 0xA3 with stop driven 0
        send_frame(0, 8'hA3, 1'b0, 1'b0, BIT_CLK);
        expect_frame(0, 8'hA3, 1'b0, 1'b0);
        idle(2 * BIT_CLK);
        score(0, "stop0");
        check("stop0_data", data_a, exp_data_a);
        check("stop0_state", st_a, ST_IDLE);

        // Short low glitch rejected as a false start
        set_rx(0, 1'b0);
        idle(8);
        check("glitch_busy", busy_a, 1'b1);
        idle(4);
        set_rx(0, 1'b1);
        idle(36);
        check("glitch_idle", busy_a, 1'b0);
        idle(BIT_CLK);
        score(0, "glitch");

        // Even parity, wrong then right parity bit
        send_frame(1, 8'h07, 1'b0, 1'b1, BIT_CLK);
        expect_frame(1, 8'h07, 1'b0, 1'b1);
        idle(BIT_CLK);
        send_frame(1, 8'h07, 1'b1, 1'b1, BIT_CLK);
        expect_frame(1, 8'h07, 1'b1, 1'b1);
        idle(BIT_CLK);
        score(1, "parity");
        check("parity_data", data_b, exp_data_b);

        // rx_enable dropped during data bit 4
        fork
            send_frame(0, 8'h3C, 1'b0, 1'b1, BIT_CLK);
            begin
                idle(5 * BIT_CLK + 32);
                en_a = 1'b0;
                idle(1);
                check("en_drop_busy", busy_a, 1'b0);
            end
        join
        idle(BIT_CLK);
        en_a = 1'b1;
        idle(BIT_CLK);
        score(0, "en_drop");
        send_frame(0, 8'h3C, 1'b0, 1'b1, BIT_CLK);
        expect_frame(0, 8'h3C, 1'b0, 1'b1);
        idle(BIT_CLK);
        score(0, "en_again");
        check("en_again_data", data_a, exp_data_a);

        // Back-to-back frames, break, recovery
        send_frame(0, 8'h01, 1'b0, 1'b1, BIT_CLK);
        expect_frame(0, 8'h01, 1'b0, 1'b1);
        send_frame(0, 8'hFE, 1'b0, 1'b1, BIT_CLK);
        expect_frame(0, 8'hFE, 1'b0, 1'b1);
        send_frame(0, 8'h80, 1'b0, 1'b1, BIT_CLK);
        expect_frame(0, 8'h80, 1'b0, 1'b1);
        set_rx(0, 1'b0);
        expect_frame(0, 8'h00, 1'b0, 1'b0);
        idle(20 * BIT_CLK - 10);
        check("break_busy", busy_a, 1'b1);
        check("break_state", st_a, ST_BREAK);
        idle(10);
        set_rx(0, 1'b1);
        idle(8);
        check("break_exit", busy_a, 1'b0);
        idle(BIT_CLK);
        send_frame(0, 8'h5A, 1'b0, 1'b1, BIT_CLK);
        expect_frame(0, 8'h5A, 1'b0, 1'b1);
        idle(BIT_CLK);
        score(0, "b2b");
        check("b2b_data", data_a, exp_data_a);

        // Random frames with up to about 3% baud mismatch
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 12; i++) begin
                b    = 8'($urandom_range(0, 255));
                stop = ($urandom_range(0, 3) != 0);
                par  = (^b) ^ ($urandom_range(0, 3) == 0);
                bc   = $urandom_range(62, 66);
                send_frame(d, b, par, stop, bc);
                expect_frame(d, b, par, stop);
                if (!stop) idle(2 * BIT_CLK);
                else       idle($urandom_range(0, 1) * BIT_CLK);
            end
            idle(2 * BIT_CLK);
            score(d, "rand");
            if (d == 0) check("rand_data_a", data_a, exp_data_a);
            else        check("rand_data_b", data_b, exp_data_b);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
